// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and the coordinate type used by the
// timing generator, draw_icon and the colorizer.
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // Active-high timing terms as carried down the delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic von;
  } vtg_terms_t;

  function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vtg_delay.sv
// Pixel-tick enabled shift register used to align sync/blank terms with the
// one-cycle icon ROM. DEPTH must be at least 1.
module vtg_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (i_en) begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// VGA timing generator: pixel divider, scan counters, delayed sync/blank and
// a frame-stable bot position (latched at vblank when VTG_POS_LATCH_EN is defined).
module video_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int CLK_DIV  = 4,
  parameter int PIPE_DLY = 1
) (
  input  logic   clk,
  input  logic   reset_n,
  output logic   pix_en,
  output coord_t horz,
  output coord_t vert,
  output logic   hsync,
  output logic   vsync,
  output logic   video_on,
  output logic   frame_start,
  input  coord_t bot_LocX_in,
  input  coord_t bot_LocY_in,
  output coord_t bot_LocX,
  output coord_t bot_LocY
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST   = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOT - 1);
  localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
  localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
  localparam coord_t HS_LO    = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t HS_HI    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO    = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t VS_HI    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam coord_t VBL_PREV = coord_t'(V_ACTIVE - 1);

  localparam logic [2:0] DIV_LAST  = 3'(CLK_DIV - 1);
  localparam int         DLY_DEPTH = (PIPE_DLY == 0) ? 1 : PIPE_DLY;
  localparam int         TERMS_W   = $bits(vtg_terms_t);

  function automatic vtg_terms_t terms_of(input coord_t h, input coord_t v);
    vtg_terms_t t;
    t.hs  = in_range(h, HS_LO, HS_HI);
    t.vs  = in_range(v, VS_LO, VS_HI);
    t.von = (h < H_ACT_C) && (v < V_ACT_C);
    return t;
  endfunction

  logic [2:0] r_div;
  logic       r_pix_en;
  coord_t     r_horz;
  coord_t     r_vert;
  logic       r_frame_start;

  logic [2:0] w_div_nxt;
  logic       w_h_wrap;
  coord_t     w_horz_nxt;
  coord_t     w_vert_nxt;
  vtg_terms_t w_raw;
  vtg_terms_t w_dly;
  logic [TERMS_W-1:0] w_dly_q;

  assign w_div_nxt  = (r_div == DIV_LAST) ? 3'd0 : r_div + 3'd1;
  assign w_h_wrap   = (r_horz == H_LAST);
  assign w_horz_nxt = w_h_wrap ? '0 : r_horz + coord_t'(1);
  assign w_vert_nxt = !w_h_wrap ? r_vert :
                      (r_vert == V_LAST) ? '0 : r_vert + coord_t'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div         <= '0;
      r_pix_en      <= 1'b0;
      r_horz        <= '0;
      r_vert        <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_pix_en      <= (w_div_nxt == DIV_LAST);
      r_frame_start <= r_pix_en && w_h_wrap && (r_vert == V_LAST);
      if (r_pix_en) begin
        r_horz <= w_horz_nxt;
        r_vert <= w_vert_nxt;
      end
    end
  end

  // With no delay the register samples the terms of the counters being loaded,
  // so outputs change on the same tick as horz/vert.
  assign w_raw = (PIPE_DLY == 0) ? terms_of(w_horz_nxt, w_vert_nxt)
                                 : terms_of(r_horz, r_vert);

  vtg_delay #(
    .WIDTH (TERMS_W),
    .DEPTH (DLY_DEPTH)
  ) u_delay (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_en    (r_pix_en),
    .i_d     (w_raw),
    .o_q     (w_dly_q)
  );

  assign w_dly       = vtg_terms_t'(w_dly_q);
  assign hsync       = w_dly.hs ? SYNC_POL : !SYNC_POL;
  assign vsync       = w_dly.vs ? SYNC_POL : !SYNC_POL;
  assign video_on    = w_dly.von;
  assign pix_en      = r_pix_en;
  assign horz        = r_horz;
  assign vert        = r_vert;
  assign frame_start = r_frame_start;

`ifdef VTG_POS_LATCH_EN
  coord_t r_bot_x;
  coord_t r_bot_y;

  // Load on the tick entering the first vblank line so the icon is frame-stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bot_x <= '0;
      r_bot_y <= '0;
    end else if (r_pix_en && w_h_wrap && (r_vert == VBL_PREV)) begin
      r_bot_x <= bot_LocX_in;
      r_bot_y <= bot_LocY_in;
    end
  end

  assign bot_LocX = r_bot_x;
  assign bot_LocY = r_bot_y;
`else
  assign bot_LocX = bot_LocX_in;
  assign bot_LocY = bot_LocY_in;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster, checked every clock against
// an arithmetic model of tick count, scan position and delayed sync terms.
module tb_video_timing_gen;
  import vga_pkg::*;

  localparam int HA = 16, HF = 4, HS = 6, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int DIV = 4, DLY = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_en, hsync, vsync, video_on, frame_start;
  logic [9:0] horz, vert, bot_LocX, bot_LocY;
  logic [9:0] bot_LocX_in = 10'd100;
  logic [9:0] bot_LocY_in = 10'd50;

  int         total = 0;
  int         bad = 0;
  int         c = 0;
  logic [9:0] cur_x = 10'd100, cur_y = 10'd50;
  logic [9:0] exp_x = '0, exp_y = '0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .CLK_DIV(DIV), .PIPE_DLY(DLY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .horz(horz), .vert(vert), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .frame_start(frame_start),
    .bot_LocX_in(bot_LocX_in), .bot_LocY_in(bot_LocY_in),
    .bot_LocX(bot_LocX), .bot_LocY(bot_LocY)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d clk=%0d", tag, obs, exp_v, c);
    end
  endtask

  task automatic check_reset_state();
`ifdef VTG_POS_LATCH_EN
    exp_x = '0;
    exp_y = '0;
`else
    exp_x = cur_x;
    exp_y = cur_y;
`endif
    chk("rst_pix_en", pix_en, 0);
    chk("rst_horz", horz, 0);
    chk("rst_vert", vert, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_video_on", video_on, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_bot_x", bot_LocX, exp_x);
    chk("rst_bot_y", bot_LocY, exp_y);
  endtask

  // Expected outputs after c clock edges since reset release.
  task automatic check_running();
    int t, s, sp, h, v, hp, vp;
    logic hs_a, vs_a, von;
    t = c / DIV;
    s = t % FRAME;
    h = s % HT;
    v = s / HT;
    hs_a = 1'b0; vs_a = 1'b0; von = 1'b0;
    if (t >= DLY) begin
      sp = (t - DLY) % FRAME;
      hp = sp % HT;
      vp = sp / HT;
      hs_a = (hp >= HA + HF) && (hp < HA + HF + HS);
      vs_a = (vp >= VA + VF) && (vp < VA + VF + VS);
      von  = (hp < HA) && (vp < VA);
    end
`ifdef VTG_POS_LATCH_EN
    if ((c % DIV == 0) && (t > 0) && (s == VA * HT)) begin
      exp_x = cur_x;
      exp_y = cur_y;
    end
`else
    exp_x = cur_x;
    exp_y = cur_y;
`endif
    chk("pix_en", pix_en, (c % DIV == DIV - 1));
    chk("horz", horz, h);
    chk("vert", vert, v);
    chk("hsync", hsync, !hs_a);
    chk("vsync", vsync, !vs_a);
    chk("video_on", video_on, von);
    chk("frame_start", frame_start, (c % DIV == 0) && (t > 0) && (s == 0));
    chk("bot_x", bot_LocX, exp_x);
    chk("bot_y", bot_LocY, exp_y);
  endtask

  task automatic step(input bit rnd);
    @(posedge clk);
    c++;
    @(negedge clk);
    check_running();
    if (rnd && ($urandom_range(0, 99) < 3)) begin
      cur_x = 10'($urandom_range(0, 1023));
      cur_y = 10'($urandom_range(0, 1023));
      bot_LocX_in = cur_x;
      bot_LocY_in = cur_y;
    end
  endtask

  task automatic async_reset_and_release(input int hold);
    #1 reset_n = 1'b0;
    #1 check_reset_state();
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_state();
    end
    reset_n = 1'b1;
    c = 0;
  endtask

  initial begin
    bit hit;
    int tt;

    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      check_reset_state();
    end
    reset_n = 1'b1;
    c = 0;

    // First frame up to just past the first vblank load, inputs steady at 100/50.
    repeat ((VA * HT + 5) * DIV) step(1'b0);

    // Move the bot to 200 mid-screen of the next frame; it must hold until vblank.
    repeat ((FRAME + (VA / 2) * HT - (VA * HT + 5)) * DIV) step(1'b0);
    cur_x = 10'd200;
    bot_LocX_in = cur_x;
    repeat (((VA / 2) * HT + 10) * DIV) step(1'b0);

    repeat (FRAME * DIV) step(1'b1);

    // Walk to a mid-frame point in the back porch and reset asynchronously.
    hit = 1'b0;
    for (int k = 0; k < FRAME * DIV && !hit; k++) begin
      step(1'b1);
      tt = c / DIV;
      hit = (c % DIV == 0) && ((tt % FRAME) == 8 * HT + HA + HF + HS);
    end
    chk("reach_reset_point", hit, 1);
    async_reset_and_release($urandom_range(3, 12));

    repeat (FRAME * DIV + 40) step(1'b1);

    repeat ($urandom_range(100, 1500)) step(1'b1);
    async_reset_and_release($urandom_range(1, 6));
    repeat (200) step(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Display timing generator for the 640x480 VGA path. It produces the `horz`/`vert` scan coordinates that the icon and map drawing stages consume, and drives the monitor sync signals and `video_on` for the colorizer. The sync/blank outputs are delayed to line up with the one-cycle synchronous icon ROM. Optionally, it latches the bot position once per frame at the start of vertical blank, so the icon never tears mid-frame.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch / sync / back porch, in pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical front porch / sync / back porch, in lines
- `SYNC_POL`, 0: sync asserted level (0 = active-low)
- `CLK_DIV`, 4: clk cycles per pixel (1..8; 4 gives 25 MHz from 100 MHz)
- `PIPE_DLY`, 1: pixel ticks of delay applied to `hsync`/`vsync`/`video_on` (0..3)

Ports:
- `clk`  in  1: system clock
- `reset_n`  in  1: asynchronous, active-low reset
- `pix_en`  out  1: one-clk pixel tick
- `horz`  out  10: pixel column counter, undelayed
- `vert`  out  10: line counter, undelayed
- `hsync`  out  1: horizontal sync, delayed `PIPE_DLY` ticks
- `vsync`  out  1: vertical sync, delayed `PIPE_DLY` ticks
- `video_on`  out  1: active-area flag, delayed `PIPE_DLY` ticks
- `frame_start`  out  1: one-clk pulse on the tick where the counters become (0,0)
- `bot_LocX_in`, `bot_LocY_in`  in  10 each: live bot position
- `bot_LocX`, `bot_LocY`  out  10 each: frame-stable bot position, fed to `draw_icon`

## Operation
- Derived constants: `H_TOTAL` = sum of the H parameters (800); `V_TOTAL` = sum of the V parameters (525). Both must be ≤1024.
- Divider: counter `0..CLK_DIV-1`. `pix_en` is registered and high for the single clk where the divider equals `CLK_DIV-1`. With `CLK_DIV=1`, `pix_en` is constantly high after reset.
- On `pix_en`:
  - `horz` increments and wraps `H_TOTAL-1`→0.
  - On that wrap, `vert` increments and wraps `V_TOTAL-1`→0.
- Raw terms, from the current counters:
  - hsync active for `horz` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = 656..751
  - vsync active for `vert` in 490..491
  - video_on when `horz`<640 and `vert`<480
- Delay line: raw terms pass through a `PIPE_DLY`-deep shift register clocked by `pix_en`. `PIPE_DLY=0` gives registered, same-tick outputs.
- Sync outputs drive `SYNC_POL` when active and `~SYNC_POL` otherwise.
- All arithmetic is unsigned 10-bit. Comparisons use the parameter-derived constants; no runtime adders.

## Timing
- Reset values:
  - divider, `horz`, `vert`: 0
  - `pix_en`, `frame_start`, `video_on`: 0
  - `hsync`, `vsync`: `~SYNC_POL`
  - all delay-line stages: inactive
  - `bot_LocX`/`bot_LocY`: 0
- First `pix_en` occurs `CLK_DIV` clks after `reset_n` deasserts. The counters first advance on that tick.
- Latency: `horz`/`vert` change in the clk after the `pix_en` clk. Delayed outputs reflect the counter value from `PIPE_DLY` ticks earlier.
- `frame_start` is asserted in the same clk that the counters load (0,0). Exactly one pulse per frame.
- Reset asserted mid-frame: everything returns to reset values immediately (async). Timing restarts from (0,0) with no partial sync pulse emitted.

## Configuration
- `VTG_POS_LATCH_EN` defined:
  - `bot_LocX`/`bot_LocY` are registers loaded from `bot_Loc*_in` on the `pix_en` tick where `vert` becomes `V_ACTIVE` and `horz` becomes 0 (start of vblank).
  - Changes to the inputs during active video do not appear until the next vblank.
- Undefined: `bot_LocX`/`bot_LocY` are combinational pass-throughs of the inputs, and the reset value does not apply.

## Structure
- The shared package `vga_pkg` holds:
  - the 640x480@60 timing constants
  - `H_TOTAL`/`V_TOTAL` as localparams
  - a `coord_t` 10-bit typedef, shared with `draw_icon` and the colorizer
- One natural sub-module: `vtg_delay`, the `pix_en`-enabled shift register, parameterised by width and depth.

## Test plan
- Reset: hold `reset_n`=0 for 10 clks, then release.
  - While held: `hsync`=`vsync`=1, `video_on`=0, `horz`=`vert`=0.
  - After release: first `pix_en` on the 4th clk.
- Cadence: `CLK_DIV`=4.
  - `pix_en` high exactly 1 of every 4 clks.
  - 800 ticks per line; `horz` wraps 799→0 while `vert` increments.
- Horizontal sync: `PIPE_DLY`=1.
  - `hsync` low while `horz` reads 657..752 (96 ticks).
  - `video_on` high while `horz` reads 1..640 on lines 0..479.
- Frame: 525 lines.
  - `vsync` low for 2 lines starting while `vert`=490, offset by one tick of `PIPE_DLY`.
  - `frame_start` pulses exactly once per 420000 ticks.
- Position latch: with `VTG_POS_LATCH_EN`, change `bot_LocX_in` 100→200 at `vert`=240.
  - `bot_LocX` stays 100 until the tick entering `vert`=480, `horz`=0, then reads 200.
  - Without the macro: output follows the input immediately.
- Mid-frame reset: assert `reset_n`=0 at `vert`=300, `horz`=700.
  - Outputs return to reset values asynchronously, without waiting for a `clk` edge.
  - After release, the next `frame_start` arrives 420000 ticks after the first counter advance.
